// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder: 16-bit frames {R/nW, addr, data} become single-cycle register
// reads/writes on the fabric bus. SCLK, MOSI and SS_n are synchronised to clk.
module spi_reg_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_ss_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_err,
  output logic [1:0]        fsm_state
);

  localparam int CMD_W   = 1 + ADDR_W;
  localparam int FRAME_W = CMD_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int RX_W    = (CMD_W > DATA_W) ? CMD_W - 1 : DATA_W - 1;
  localparam logic [CNT_W-1:0] CMD_BITS   = CNT_W'(CMD_W);
  localparam logic [CNT_W-1:0] FRAME_BITS = CNT_W'(FRAME_W);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, ss_sr, arm_sr;
  logic                   sclk_s, mosi_s, ss_s;
  logic                   sclk_q, ss_q, armed;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

  logic [1:0]             state;
  logic [CNT_W-1:0]       bit_cnt, cnt_inc;
  logic [RX_W-1:0]        rx;
  logic [RX_W:0]          rx_shift;
  logic [DATA_W-1:0]      tx;
  logic                   is_read, rd_q, done_err;

  // SS_n chain resets high so the output enable stays off until a real low is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sr <= '0;
      mosi_sr <= '0;
      ss_sr   <= '1;
      arm_sr  <= '0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], spi_sclk};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      ss_sr   <= {ss_sr[SYNC_STAGES-2:0], spi_ss_n};
      arm_sr  <= {arm_sr[SYNC_STAGES-2:0], spi_ss_n};
    end
  end

  assign sclk_s = sclk_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];
  assign ss_s   = ss_sr[SYNC_STAGES-1];

  // armed only sets after SS_n is genuinely observed high, so a select held low through
  // reset cannot start a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q <= 1'b0;
      ss_q   <= 1'b1;
      armed  <= 1'b0;
    end else begin
      sclk_q <= sclk_s;
      ss_q   <= ss_s;
      armed  <= armed | arm_sr[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign ss_rise   = ss_s & ~ss_q;
  assign ss_fall   = ~ss_s & ss_q & armed;

  assign cnt_inc  = (bit_cnt == FRAME_BITS) ? bit_cnt : bit_cnt + CNT_W'(1);
  assign rx_shift = {rx, mosi_s};

  // Bus strobes: reg_wr/reg_rd are single-cycle, reg_addr/reg_wdata are valid with them;
  // the fabric returns reg_rdata one clk after reg_rd and there is no back-pressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx        <= '0;
      tx        <= '0;
      is_read   <= 1'b0;
      rd_q      <= 1'b0;
      done_err  <= 1'b0;
      spi_miso  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
      rd_q      <= reg_rd;
      if (rd_q) tx <= reg_rdata;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            bit_cnt  <= '0;
            rx       <= '0;
            spi_miso <= 1'b0;
            done_err <= 1'b0;
            state    <= CMD;
          end
        end
        CMD: begin
          if (ss_rise) begin
            frame_err <= 1'b1;
            spi_miso  <= 1'b0;
            state     <= IDLE;
          end else if (sclk_rise) begin
            rx      <= rx_shift[RX_W-1:0];
            bit_cnt <= cnt_inc;
            if (cnt_inc == CMD_BITS) begin
              reg_addr <= rx_shift[ADDR_W-1:0];
              is_read  <= rx_shift[CMD_W-1];
              reg_rd   <= rx_shift[CMD_W-1];
              state    <= DATA;
            end
          end
        end
        DATA: begin
          // A 16th rise coinciding with SS_n release still completes the frame.
          if (sclk_rise && cnt_inc == FRAME_BITS) begin
            rx       <= rx_shift[RX_W-1:0];
            bit_cnt  <= cnt_inc;
            spi_miso <= 1'b0;
            if (!is_read) begin
              reg_wr    <= 1'b1;
              reg_wdata <= rx_shift[DATA_W-1:0];
            end
            state <= ss_rise ? IDLE : DONE;
          end else if (ss_rise) begin
            frame_err <= 1'b1;
            spi_miso  <= 1'b0;
            state     <= IDLE;
          end else if (sclk_rise) begin
            rx      <= rx_shift[RX_W-1:0];
            bit_cnt <= cnt_inc;
          end else if (sclk_fall && is_read) begin
            spi_miso <= tx[DATA_W-1];
            tx       <= {tx[DATA_W-2:0], 1'b0};
          end
        end
        DONE: begin
          spi_miso <= 1'b0;
          if (ss_rise) begin
            state <= IDLE;
          end else if (sclk_rise) begin
            bit_cnt <= cnt_inc;
            if (!done_err) begin
              frame_err <= 1'b1;
              done_err  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign spi_miso_oe = ~ss_s;
  assign busy        = (state != IDLE);
  assign fsm_state   = state;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: SPI master driver at f_clk/8, fabric register
// model with one-clk read latency, per-scenario tasks with inline checks.
module tb_spi_reg_responder;

  logic       clk, reset;
  logic       spi_sclk, spi_mosi, spi_ss_n;
  logic       spi_miso, spi_miso_oe;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic       reg_wr, reg_rd, busy, frame_err;
  logic [1:0] fsm_state;

  int         checks, failures;
  int         wr_cnt, rd_cnt, err_cnt;
  logic [6:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic [31:0] miso_cap;
  logic       oe_cap;
  logic       rd_d;
  logic [7:0] mem [0:127];

  spi_reg_responder dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
    .busy(busy), .frame_err(frame_err), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fabric model: rdata valid only in the clk after reg_rd, garbage otherwise.
  always @(negedge clk) begin
    if (rd_d) reg_rdata = mem[reg_addr];
    else      reg_rdata = 8'hEE;
    rd_d = reg_rd;
  end

  // Bus monitor / scoreboard state
  always @(negedge clk) begin
    if (reg_wr === 1'b1) begin
      wr_cnt++;
      wr_addr = reg_addr;
      wr_data = reg_wdata;
      mem[reg_addr] = reg_wdata;
    end
    if (reg_rd === 1'b1) begin
      rd_cnt++;
      rd_addr = reg_addr;
    end
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic clear_counts();
    wr_cnt = 0; rd_cnt = 0; err_cnt = 0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    miso_cap = '0; oe_cap = 1'b0;
  endtask

  // SPI master driver: SCLK half-period 4 clk; MISO sampled just before each rise.
  task automatic spi_xfer(input logic [15:0] word, input int nbits, input int gap);
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 16) ? word[15-i] : 1'b1;
      repeat (4) @(negedge clk);
      miso_cap[i] = spi_miso;
      if (i == 0) oe_cap = spi_miso_oe;
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({spi_miso, spi_miso_oe, reg_wr, reg_rd, busy, frame_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {spi_miso, spi_miso_oe, reg_wr, reg_rd, busy, frame_err});
    end
    checks++;
    if ({reg_addr, reg_wdata, fsm_state} !== 17'h0) begin
      failures++;
      $display("FAIL reset_bus got addr=%h wdata=%h state=%0d exp 0", reg_addr, reg_wdata, fsm_state);
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if ({busy, spi_miso_oe, fsm_state} !== 4'b0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b oe=%b state=%0d exp 0", busy, spi_miso_oe, fsm_state);
    end
  endtask

  task automatic test_write();
    clear_counts();
    spi_xfer(16'h2A5C, 16, 6);
    checks++;
    if (wr_cnt !== 1 || rd_cnt !== 0 || err_cnt !== 0) begin
      failures++;
      $display("FAIL write_strobes got wr=%0d rd=%0d err=%0d exp 1 0 0", wr_cnt, rd_cnt, err_cnt);
    end
    checks++;
    if (wr_addr !== 7'h2A || wr_data !== 8'h5C) begin
      failures++;
      $display("FAIL write_fields got addr=%h data=%h exp 2a 5c", wr_addr, wr_data);
    end
    checks++;
    if (miso_cap[15:0] !== 16'h0) begin
      failures++;
      $display("FAIL write_miso got=%h exp=0000", miso_cap[15:0]);
    end
    checks++;
    if (oe_cap !== 1'b1 || busy !== 1'b0 || reg_addr !== 7'h2A) begin
      failures++;
      $display("FAIL write_after got oe=%b busy=%b addr=%h exp 1 0 2a", oe_cap, busy, reg_addr);
    end
  endtask

  task automatic test_read();
    logic [7:0] got;
    clear_counts();
    spi_xfer(16'h8300, 16, 6);
    for (int i = 0; i < 8; i++) got[7-i] = miso_cap[8+i];
    checks++;
    if (rd_cnt !== 1 || wr_cnt !== 0 || err_cnt !== 0 || rd_addr !== 7'h03) begin
      failures++;
      $display("FAIL read_strobes got rd=%0d wr=%0d err=%0d addr=%h exp 1 0 0 03",
               rd_cnt, wr_cnt, err_cnt, rd_addr);
    end
    checks++;
    if (got !== 8'hC3) begin
      failures++;
      $display("FAIL read_miso_data got=%h exp=c3", got);
    end
    checks++;
    if (miso_cap[7:0] !== 8'h00 || reg_addr !== 7'h03) begin
      failures++;
      $display("FAIL read_cmd_phase got miso=%h addr=%h exp 00 03", miso_cap[7:0], reg_addr);
    end
  endtask

  task automatic test_abort();
    clear_counts();
    spi_xfer(16'h1155, 11, 6);
    checks++;
    if (err_cnt !== 1 || wr_cnt !== 0) begin
      failures++;
      $display("FAIL abort_err got err=%0d wr=%0d exp 1 0", err_cnt, wr_cnt);
    end
    checks++;
    if (busy !== 1'b0 || fsm_state !== 2'd0) begin
      failures++;
      $display("FAIL abort_idle got busy=%b state=%0d exp 0 0", busy, fsm_state);
    end
    clear_counts();
    spi_xfer(16'h3377, 16, 6);
    checks++;
    if (wr_cnt !== 1 || err_cnt !== 0 || wr_addr !== 7'h33 || wr_data !== 8'h77) begin
      failures++;
      $display("FAIL abort_recover got wr=%0d err=%0d addr=%h data=%h exp 1 0 33 77",
               wr_cnt, err_cnt, wr_addr, wr_data);
    end
  endtask

  task automatic test_overlong();
    clear_counts();
    spi_xfer(16'h7FFF, 20, 6);
    checks++;
    if (wr_cnt !== 1 || wr_addr !== 7'h7F || wr_data !== 8'hFF) begin
      failures++;
      $display("FAIL overlong_write got wr=%0d addr=%h data=%h exp 1 7f ff", wr_cnt, wr_addr, wr_data);
    end
    checks++;
    if (err_cnt !== 1 || rd_cnt !== 0) begin
      failures++;
      $display("FAIL overlong_err got err=%0d rd=%0d exp 1 0", err_cnt, rd_cnt);
    end
    checks++;
    if (miso_cap[19:16] !== 4'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL overlong_tail got miso=%h busy=%b exp 0 0", miso_cap[19:16], busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] word;
    clear_counts();
    word = 16'h8300;
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      spi_mosi = word[15-i];
      repeat (4) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
    end
    spi_mosi = word[5];
    repeat (4) @(negedge clk);
    spi_sclk = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({spi_miso, spi_miso_oe, reg_wr, reg_rd, busy, frame_err, fsm_state} !== 8'b0 ||
        reg_addr !== 7'h0 || reg_wdata !== 8'h0) begin
      failures++;
      $display("FAIL midreset_outputs got miso=%b oe=%b busy=%b state=%0d addr=%h exp all 0",
               spi_miso, spi_miso_oe, busy, fsm_state, reg_addr);
    end
    spi_sclk = 1'b0;
    spi_ss_n = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    clear_counts();
    spi_xfer(16'h0101, 16, 6);
    checks++;
    if (wr_cnt !== 1 || rd_cnt !== 0 || err_cnt !== 0 || wr_addr !== 7'h01 || wr_data !== 8'h01) begin
      failures++;
      $display("FAIL midreset_next got wr=%0d rd=%0d err=%0d addr=%h data=%h exp 1 0 0 01 01",
               wr_cnt, rd_cnt, err_cnt, wr_addr, wr_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    clear_counts();
    spi_xfer(16'h0A11, 16, 2);
    spi_xfer(16'h8A00, 16, 6);
    for (int i = 0; i < 8; i++) got[7-i] = miso_cap[8+i];
    checks++;
    if (wr_cnt !== 1 || wr_addr !== 7'h0A || wr_data !== 8'h11) begin
      failures++;
      $display("FAIL b2b_write got wr=%0d addr=%h data=%h exp 1 0a 11", wr_cnt, wr_addr, wr_data);
    end
    checks++;
    if (rd_cnt !== 1 || rd_addr !== 7'h0A || err_cnt !== 0) begin
      failures++;
      $display("FAIL b2b_read got rd=%0d addr=%h err=%0d exp 1 0a 0", rd_cnt, rd_addr, err_cnt);
    end
    checks++;
    if (got !== 8'h11) begin
      failures++;
      $display("FAIL b2b_read_data got=%h exp=11", got);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
    rd_d = 1'b0; reg_rdata = 8'h00;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[3] = 8'hC3;
    clear_counts();
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_overlong();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
